// File: rtl/instr_loader.sv
// -----------------------------------------------------------------------------
// instr_loader
//
// Writes a program into instruction memory before the core starts fetching.
// Bytes arrive over a valid/ready stream. Each group of DATA_WIDTH/8 bytes is
// packed little-endian into one word. That word is written through a
// single-cycle write port to word addresses 0, 1, 2, ... The core is held in
// reset while a load is in progress.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   start       begin a load (only looked at in IDLE/DONE)
//   word_count  number of words to load, clamped to 2**ADDRESS_WIDTH
//   byte_in     stream byte
//   byte_valid  byte_in is valid
//   byte_ready  loader accepts a byte this cycle (RECV only)
//   mem_we      instruction-memory write enable (WRITE only)
//   mem_addr    word address of the write (holds last value)
//   mem_wdata   word to write (holds last value)
//   cpu_hold    hold the core in reset while loading
//   busy        load in progress (RECV or WRITE)
//   done        load finished; held until the next accepted start
// -----------------------------------------------------------------------------
module instr_loader #(
   parameter int ADDRESS_WIDTH = 5,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [ADDRESS_WIDTH:0]   word_count,
   input  logic [7:0]               byte_in,
   input  logic                     byte_valid,
   output logic                     byte_ready,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic                     cpu_hold,
   output logic                     busy,
   output logic                     done
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(BYTES - 1);
   localparam logic [ADDRESS_WIDTH:0] MAX_WORDS = {1'b1, {ADDRESS_WIDTH{1'b0}}};

   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

   state_t                   state;
   logic [IDX_W-1:0]         idx;
   logic [ADDRESS_WIDTH:0]   n_words;
   logic [ADDRESS_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0]    partial;
   logic                     hold;

   logic [ADDRESS_WIDTH:0]   n_clamped;
   logic [DATA_WIDTH-1:0]    word_next;
   logic                     last_word;

   // Place byte b into byte lane i of word w (lane 0 = bits [7:0]).
   function automatic logic [DATA_WIDTH-1:0] insert_byte(
      input logic [DATA_WIDTH-1:0] w,
      input logic [IDX_W-1:0]      i,
      input logic [7:0]            b
   );
      logic [DATA_WIDTH-1:0] r;
      r = w;
      for (int k = 0; k < BYTES; k++) begin
         if (i == IDX_W'(k)) r[8*k +: 8] = b;
      end
      return r;
   endfunction

   // The clamp keeps the word address inside memory, so it never wraps.
   assign n_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
   assign word_next = insert_byte(partial, idx, byte_in);
   assign last_word = ({1'b0, waddr} == (n_words - 1'b1));

   assign busy     = hold;
   assign cpu_hold = hold;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         n_words    <= '0;
         waddr      <= '0;
         partial    <= '0;
         hold       <= 1'b0;
         byte_ready <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         done       <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  n_words <= n_clamped;
                  waddr   <= '0;
                  idx     <= '0;
                  if (n_clamped == '0) begin
                     state <= DONE;
                     done  <= 1'b1;
                  end else begin
                     state      <= RECV;
                     done       <= 1'b0;
                     byte_ready <= 1'b1;
                     hold       <= 1'b1;
                  end
               end
            end
            RECV: begin
               // byte_ready is 1 throughout RECV, so byte_valid alone is the handshake.
               if (byte_valid) begin
                  partial <= word_next;
                  if (idx == LAST_IDX) begin
                     // Registered so the write appears the cycle after the last byte.
                     idx        <= '0;
                     state      <= WRITE;
                     byte_ready <= 1'b0;
                     mem_we     <= 1'b1;
                     mem_addr   <= waddr;
                     mem_wdata  <= word_next;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            WRITE: begin
               if (last_word) begin
                  state <= DONE;
                  done  <= 1'b1;
                  hold  <= 1'b0;
               end else begin
                  waddr      <= waddr + 1'b1;
                  state      <= RECV;
                  byte_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_loader
//
// Self-checking bench for instr_loader. A byte program is kept in a queue.
// The expected word k is rebuilt from bytes 4k..4k+3 of that queue. The bench
// follows the stream at transaction level: it counts accepted bytes, and after
// every fourth accepted byte it expects exactly one write cycle carrying the
// next address and word. It then checks the end-of-load status.
// -----------------------------------------------------------------------------
module tb_instr_loader;

   localparam int AW   = 5;
   localparam int DW   = 32;
   localparam int BPW  = DW / 8;
   localparam int MAXW = 1 << AW;

   logic          clk;
   logic          rst;
   logic          start;
   logic [AW:0]   word_count;
   logic [7:0]    byte_in;
   logic          byte_valid;
   logic          byte_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          cpu_hold;
   logic          busy;
   logic          done;

   int checks   = 0;
   int failures = 0;

   logic [7:0] prog[$];

   instr_loader #(
      .ADDRESS_WIDTH (AW),
      .DATA_WIDTH    (DW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .word_count (word_count),
      .byte_in    (byte_in),
      .byte_valid (byte_valid),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] exp_word(input int k);
      logic [DW-1:0] w;
      for (int b = 0; b < BPW; b++) w[8*b +: 8] = prog[BPW*k + b];
      return w;
   endfunction

   task automatic fill_random(input int nbytes);
      prog.delete();
      for (int i = 0; i < nbytes; i++) prog.push_back(8'($urandom));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_we"},    64'(mem_we),     64'(0));
      chk({tag, "_addr"},  64'(mem_addr),   64'(0));
      chk({tag, "_wdata"}, 64'(mem_wdata),  64'(0));
      chk({tag, "_ready"}, 64'(byte_ready), 64'(0));
      chk({tag, "_busy"},  64'(busy),       64'(0));
      chk({tag, "_hold"},  64'(cpu_hold),   64'(0));
      chk({tag, "_done"},  64'(done),       64'(0));
   endtask

   // One load of wc words. duty    = percentage of cycles with byte_valid=1.
   //                       busy_word = word index during whose RECV a stray
   //                                   start is pulsed (-1 = none).
   //                       abort_acc = return once this many bytes are
   //                                   accepted (-1 = run to completion).
   task automatic run_load(input int wc, input int duty, input int busy_word, input int abort_acc);
      int n, wr, acc, cyc;
      bit pend, sb_used, aborted, v;
      n = (wc > MAXW) ? MAXW : wc;
      start      = 1'b1;
      word_count = (AW+1)'(wc);
      byte_valid = 1'b0;
      step();
      start = 1'b0;
      chk("start_done", 64'(done),     64'(n == 0));
      chk("start_busy", 64'(busy),     64'(n != 0));
      chk("start_hold", 64'(cpu_hold), 64'(n != 0));
      chk("start_we",   64'(mem_we),   64'(0));
      if (n == 0) begin
         step();
         chk("zero_we",   64'(mem_we), 64'(0));
         chk("zero_done", 64'(done),   64'(1));
         return;
      end
      wr = 0; acc = 0; pend = 0; cyc = 0; sb_used = 0; aborted = 0;
      while (wr < n && cyc < 20000) begin
         if (!pend && abort_acc >= 0 && acc == abort_acc) begin
            aborted = 1;
            break;
         end
         chk("busy",     64'(busy), 64'(1));
         chk("done_low", 64'(done), 64'(0));
         if (pend) begin
            chk("we",       64'(mem_we),     64'(1));
            chk("addr",     64'(mem_addr),   64'(wr));
            chk("wdata",    64'(mem_wdata),  64'(exp_word(wr)));
            chk("ready_wr", 64'(byte_ready), 64'(0));
            wr++;
            pend = 0;
            // Bytes offered during the write cycle must not be taken.
            byte_valid = 1'($urandom_range(0, 1));
            byte_in    = 8'($urandom);
         end else begin
            chk("we_recv", 64'(mem_we),     64'(0));
            chk("ready",   64'(byte_ready), 64'(1));
            if (wr == busy_word && !sb_used) begin
               sb_used    = 1;
               start      = 1'b1;
               word_count = (AW+1)'(7);
            end
            v = (int'($urandom_range(0, 99)) < duty);
            byte_valid = v;
            byte_in    = v ? prog[acc] : 8'($urandom);
            if (v) begin
               acc++;
               if (acc % BPW == 0) pend = 1;
            end
         end
         step();
         start = 1'b0;
         cyc++;
      end
      byte_valid = 1'b0;
      if (aborted) return;
      chk("load_complete", 64'(wr),         64'(n));
      chk("end_done",      64'(done),       64'(1));
      chk("end_busy",      64'(busy),       64'(0));
      chk("end_hold",      64'(cpu_hold),   64'(0));
      chk("end_ready",     64'(byte_ready), 64'(0));
      chk("end_we",        64'(mem_we),     64'(0));
      chk("end_addr",      64'(mem_addr),   64'(n - 1));
      chk("end_wdata",     64'(mem_wdata),  64'(exp_word(n - 1)));
      byte_valid = 1'b1;
      byte_in    = 8'hAA;
      step();
      byte_valid = 1'b0;
      chk("done_held",  64'(done),       64'(1));
      chk("done_we",    64'(mem_we),     64'(0));
      chk("done_ready", 64'(byte_ready), 64'(0));
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      word_count = '0;
      byte_in    = '0;
      byte_valid = 1'b0;
      repeat (3) step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_done", 64'(done), 64'(0));

      // Basic program, continuous stream.
      prog = {8'h13, 8'h05, 8'h10, 8'h00,
              8'h13, 8'h05, 8'h15, 8'h00,
              8'h13, 8'h05, 8'h15, 8'h00,
              8'h13, 8'h05, 8'h15, 8'h00,
              8'h13, 8'h05, 8'h15, 8'h00,
              8'h6f, 8'h00, 8'h00, 8'h00};
      chk("prog_w0", 64'(exp_word(0)), 64'(32'h00100513));
      chk("prog_w5", 64'(exp_word(5)), 64'(32'h0000006f));
      run_load(6, 100, -1, -1);

      // Same program with a sparse stream; restarts from DONE.
      run_load(6, 30, -1, -1);

      // Zero-length load.
      run_load(0, 100, -1, -1);

      // Clamp: 40 requested, 32 written.
      fill_random(4 * 40);
      run_load(40, 70, -1, -1);

      // Stray start during RECV of word 1 is ignored.
      fill_random(8);
      run_load(2, 60, 1, -1);

      // Reset after two bytes of word 3; start in the same cycle loses to rst.
      fill_random(24);
      run_load(6, 80, -1, 3 * BPW + 2);
      start      = 1'b1;
      word_count = (AW+1)'(3);
      rst        = 1'b1;
      step();
      rst   = 1'b0;
      start = 1'b0;
      chk_all_zero("midreset");
      for (int i = 0; i < 3; i++) begin
         byte_valid = 1'b1;
         byte_in    = 8'($urandom);
         step();
         chk("post_rst_we",    64'(mem_we),     64'(0));
         chk("post_rst_ready", 64'(byte_ready), 64'(0));
         chk("post_rst_busy",  64'(busy),       64'(0));
      end
      byte_valid = 1'b0;
      fill_random(4);
      run_load(1, 100, -1, -1);

      // Restart from DONE with a single known word.
      prog = {8'hEF, 8'hBE, 8'hAD, 8'hDE};
      run_load(1, 50, -1, -1);
      chk("deadbeef", 64'(mem_wdata), 64'(32'hDEADBEEF));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
